// File: rtl/trojan_trig_pkg.sv
// Shared types and helpers for the sequence trigger: FSM encoding, default pattern, pattern slicer.
package trojan_trig_pkg;

   typedef enum logic [1:0] {IDLE, TRACK, FIRED} trig_state_t;

   localparam logic [127:0] DEFAULT_PATTERN = 128'h00112233_44556677_8899aabb_ccddeeff;

   // Widest flattened pattern table the slicer handles (SEQ_LEN*DATA_W must fit).
   localparam int PAT_MAX = 4096;

   // Element idx of the flat table ends up in the low data_w bits of the result.
   function automatic logic [PAT_MAX-1:0] pat_sel(input logic [PAT_MAX-1:0] patterns,
                                                  input int unsigned idx,
                                                  input int unsigned data_w = 128);
      return patterns >> (idx * data_w);
   endfunction

endpackage

// File: rtl/trojan_pattern_cmp.sv
// Stage-1 compare: registers the beat's valid plus "matches expected step" and "matches first step".
// Optional per-bit compare mask when TROJAN_TRIG_MASK_EN is defined.
module trojan_pattern_cmp
   import trojan_trig_pkg::*;
#(
   parameter int                         DATA_W   = 128,
   parameter int                         SEQ_LEN  = 4,
   parameter logic [SEQ_LEN*DATA_W-1:0]  PATTERNS = {SEQ_LEN{DEFAULT_PATTERN}},
   parameter int                         IW       = $clog2(SEQ_LEN+1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] data_in,
   input  logic [IW-1:0]     idx,
`ifdef TROJAN_TRIG_MASK_EN
   input  logic [DATA_W-1:0] cmp_mask,
`endif
   output logic              hit_vld,
   output logic              hit_cur,
   output logic              hit_first
);

   localparam logic [PAT_MAX-1:0] PAT_PAD = PAT_MAX'(PATTERNS);

   logic [DATA_W-1:0] pat_cur, pat_first, mask;
   logic              match_cur, match_first;

`ifdef TROJAN_TRIG_MASK_EN
   assign mask = cmp_mask;
`else
   assign mask = '1;
`endif

   assign pat_cur     = DATA_W'(pat_sel(PAT_PAD, 32'(idx), DATA_W));
   assign pat_first   = DATA_W'(pat_sel(PAT_PAD, 0, DATA_W));
   assign match_cur   = ((data_in ^ pat_cur)   & mask) == '0;
   assign match_first = ((data_in ^ pat_first) & mask) == '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hit_vld   <= 1'b0;
         hit_cur   <= 1'b0;
         hit_first <= 1'b0;
      end else if (flush) begin
         hit_vld   <= 1'b0;
         hit_cur   <= 1'b0;
         hit_first <= 1'b0;
      end else begin
         hit_vld   <= in_valid;
         hit_cur   <= in_valid & match_cur;
         hit_first <= in_valid & match_first;
      end
   end

endmodule

// File: rtl/trojan_seq_trigger.sv
// Ordered multi-pattern trigger with bounded gap, sticky trig and saturating fire count.
// Optional feature macro: TROJAN_TRIG_MASK_EN (adds cmp_mask input).
module trojan_seq_trigger
   import trojan_trig_pkg::*;
#(
   parameter int                         DATA_W   = 128,
   parameter int                         SEQ_LEN  = 4,
   parameter logic [SEQ_LEN*DATA_W-1:0]  PATTERNS = {SEQ_LEN{DEFAULT_PATTERN}},
   parameter int                         MAX_GAP  = 8,
   parameter int                         CNT_W    = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           in_valid,
   input  logic [DATA_W-1:0]              data_in,
`ifdef TROJAN_TRIG_MASK_EN
   input  logic [DATA_W-1:0]              cmp_mask,
`endif
   input  logic                           clear,
   output logic                           trig,
   output logic [$clog2(SEQ_LEN+1)-1:0]   progress,
   output logic [CNT_W-1:0]               fire_cnt
);

   localparam int PW = $clog2(SEQ_LEN+1);
   localparam int GW = $clog2(MAX_GAP+1);

   trig_state_t   state, state_nxt;
   logic [PW-1:0] progress_nxt, cmp_idx;
   logic [GW-1:0] gap, gap_nxt;
   logic          trig_nxt, do_fire;
   logic          s1_vld, s1_hit_cur, s1_hit_first;

   // The beat sampled now is judged by the FSM next cycle, so it must be
   // compared against the step index the FSM is about to hold.
   assign cmp_idx = (progress_nxt < PW'(SEQ_LEN)) ? progress_nxt : '0;

   trojan_pattern_cmp #(
      .DATA_W   (DATA_W),
      .SEQ_LEN  (SEQ_LEN),
      .PATTERNS (PATTERNS),
      .IW       (PW)
   ) u_cmp (
      .clk       (clk),
      .rst       (rst),
      .flush     (clear),
      .in_valid  (in_valid),
      .data_in   (data_in),
      .idx       (cmp_idx),
`ifdef TROJAN_TRIG_MASK_EN
      .cmp_mask  (cmp_mask),
`endif
      .hit_vld   (s1_vld),
      .hit_cur   (s1_hit_cur),
      .hit_first (s1_hit_first)
   );

   always_comb begin
      state_nxt    = state;
      progress_nxt = progress;
      gap_nxt      = gap;
      trig_nxt     = trig;
      do_fire      = 1'b0;
      if (clear) begin
         state_nxt    = IDLE;
         progress_nxt = '0;
         gap_nxt      = '0;
         trig_nxt     = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (s1_vld && s1_hit_first) begin
                  if (SEQ_LEN == 1) begin
                     do_fire = 1'b1;
                  end else begin
                     state_nxt    = TRACK;
                     progress_nxt = PW'(1);
                     gap_nxt      = '0;
                  end
               end
            end
            TRACK: begin
               if (s1_vld) begin
                  if (s1_hit_cur) begin
                     if (progress == PW'(SEQ_LEN-1)) begin
                        do_fire = 1'b1;
                     end else begin
                        progress_nxt = progress + PW'(1);
                        gap_nxt      = '0;
                     end
                  end else if (s1_hit_first) begin
                     progress_nxt = PW'(1);
                     gap_nxt      = '0;
                  end else if (gap == GW'(MAX_GAP-1)) begin
                     state_nxt    = IDLE;
                     progress_nxt = '0;
                     gap_nxt      = '0;
                  end else begin
                     gap_nxt = gap + GW'(1);
                  end
               end
            end
            FIRED: ;
            default: begin
               state_nxt    = IDLE;
               progress_nxt = '0;
               gap_nxt      = '0;
            end
         endcase
         if (do_fire) begin
            state_nxt    = FIRED;
            progress_nxt = PW'(SEQ_LEN);
            gap_nxt      = '0;
            trig_nxt     = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         progress <= '0;
         gap      <= '0;
         trig     <= 1'b0;
         fire_cnt <= '0;
      end else begin
         state    <= state_nxt;
         progress <= progress_nxt;
         gap      <= gap_nxt;
         trig     <= trig_nxt;
         if (do_fire && (fire_cnt != '1))
            fire_cnt <= fire_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_trojan_seq_trigger.sv
// Directed bench: 4-step instance with distinct patterns plus a 1-step instance on the default pattern.
module tb_trojan_seq_trigger;
   import trojan_trig_pkg::*;

   localparam logic [127:0] P0 = 128'h0123_4567_89ab_cdef_0000_0000_0000_00a0;
   localparam logic [127:0] P1 = 128'h1111_2222_3333_4444_5555_6666_7777_88a1;
   localparam logic [127:0] P2 = 128'hfeed_face_cafe_beef_0000_0000_0000_00a2;
   localparam logic [127:0] P3 = 128'h0f0f_0f0f_f0f0_f0f0_a5a5_5a5a_0000_00a3;
   localparam logic [127:0] JUNK = 128'hdead_dead_dead_dead_dead_dead_dead_dead;
   localparam logic [511:0] PATS = {P3, P2, P1, P0};

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         in_valid = 1'b0, clear = 1'b0;
   logic [127:0] data_in = '0;
   logic         trig;
   logic [2:0]   progress;
   logic [7:0]   fire_cnt;
   logic         in_valid1 = 1'b0, clear1 = 1'b0;
   logic [127:0] data_in1 = '0;
   logic         trig1;
   logic [0:0]   progress1;
   logic [7:0]   fire_cnt1;
`ifdef TROJAN_TRIG_MASK_EN
   logic [127:0] mask0 = '1;
   logic [127:0] mask1 = '1;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   trojan_seq_trigger #(.DATA_W(128), .SEQ_LEN(4), .PATTERNS(PATS), .MAX_GAP(8), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in),
`ifdef TROJAN_TRIG_MASK_EN
      .cmp_mask(mask0),
`endif
      .clear(clear), .trig(trig), .progress(progress), .fire_cnt(fire_cnt));

   trojan_seq_trigger #(.DATA_W(128), .SEQ_LEN(1), .PATTERNS(DEFAULT_PATTERN), .MAX_GAP(8), .CNT_W(8)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid1), .data_in(data_in1),
`ifdef TROJAN_TRIG_MASK_EN
      .cmp_mask(mask1),
`endif
      .clear(clear1), .trig(trig1), .progress(progress1), .fire_cnt(fire_cnt1));

   // One clock on the 4-step instance; outputs are settled on return.
   task automatic step(input logic v, input logic [127:0] d, input logic c);
      in_valid = v; data_in = d; clear = c;
      @(posedge clk); #1;
      in_valid = 1'b0; clear = 1'b0;
   endtask

   task automatic step1(input logic v, input logic [127:0] d, input logic c);
      in_valid1 = v; data_in1 = d; clear1 = c;
      @(posedge clk); #1;
      in_valid1 = 1'b0; clear1 = 1'b0;
   endtask

   task automatic test_reset;
      #2;
      n_vec++; if (trig !== 1'b0) begin n_err++; $display("FAIL reset_trig got %0b want 0", trig); end
      n_vec++; if (progress !== 3'd0) begin n_err++; $display("FAIL reset_progress got %0d want 0", progress); end
      n_vec++; if (fire_cnt !== 8'd0) begin n_err++; $display("FAIL reset_fire_cnt got %0d want 0", fire_cnt); end
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic;
      step(1, P0, 0);
      n_vec++; if (progress !== 3'd0) begin n_err++; $display("FAIL basic_prog_lag got %0d want 0", progress); end
      step(1, P1, 0);
      n_vec++; if (progress !== 3'd1) begin n_err++; $display("FAIL basic_prog1 got %0d want 1", progress); end
      step(1, P2, 0);
      step(1, P3, 0);
      n_vec++; if (trig !== 1'b0) begin n_err++; $display("FAIL basic_trig_early got %0b want 0", trig); end
      step(0, '0, 0);
      n_vec++; if (trig !== 1'b1) begin n_err++; $display("FAIL basic_trig got %0b want 1", trig); end
      n_vec++; if (progress !== 3'd4) begin n_err++; $display("FAIL basic_progress got %0d want 4", progress); end
      n_vec++; if (fire_cnt !== 8'd1) begin n_err++; $display("FAIL basic_fire_cnt got %0d want 1", fire_cnt); end
      for (int i = 0; i < 4; i++) step(1, P0, 0);
      step(0, '0, 0);
      n_vec++; if (trig !== 1'b1 || fire_cnt !== 8'd1) begin n_err++; $display("FAIL fired_sticky got trig=%0b cnt=%0d want 1/1", trig, fire_cnt); end
      step(0, '0, 1);
      n_vec++; if (trig !== 1'b0 || progress !== 3'd0) begin n_err++; $display("FAIL clear got trig=%0b prog=%0d want 0/0", trig, progress); end
      n_vec++; if (fire_cnt !== 8'd1) begin n_err++; $display("FAIL clear_keeps_cnt got %0d want 1", fire_cnt); end
   endtask

   task automatic test_gap;
      step(1, P0, 0); step(1, P1, 0);
      for (int i = 0; i < 7; i++) step(1, JUNK, 0);
      step(0, '0, 0);
      n_vec++; if (progress !== 3'd2) begin n_err++; $display("FAIL gap7_progress got %0d want 2", progress); end
      step(1, P2, 0); step(1, P3, 0); step(0, '0, 0);
      n_vec++; if (trig !== 1'b1 || fire_cnt !== 8'd2) begin n_err++; $display("FAIL gap7_fire got trig=%0b cnt=%0d want 1/2", trig, fire_cnt); end
      step(0, '0, 1);
      step(1, P0, 0); step(1, P1, 0);
      for (int i = 0; i < 8; i++) step(1, JUNK, 0);
      step(0, '0, 0);
      n_vec++; if (progress !== 3'd0) begin n_err++; $display("FAIL gap8_abort got %0d want 0", progress); end
      step(1, P2, 0); step(1, P3, 0); step(0, '0, 0); step(0, '0, 0);
      n_vec++; if (trig !== 1'b0 || fire_cnt !== 8'd2) begin n_err++; $display("FAIL gap8_nofire got trig=%0b cnt=%0d want 0/2", trig, fire_cnt); end
   endtask

   task automatic test_restart;
      step(1, P0, 0); step(1, P1, 0); step(1, P0, 0); step(0, '0, 0);
      n_vec++; if (progress !== 3'd1) begin n_err++; $display("FAIL restart_progress got %0d want 1", progress); end
      step(1, P1, 0);
      for (int i = 0; i < 20; i++) step(0, '0, 0);
      n_vec++; if (progress !== 3'd2) begin n_err++; $display("FAIL idle_hold got %0d want 2", progress); end
      step(1, P2, 0); step(1, P3, 0); step(0, '0, 0);
      n_vec++; if (trig !== 1'b1 || progress !== 3'd4 || fire_cnt !== 8'd3) begin n_err++; $display("FAIL restart_fire got trig=%0b prog=%0d cnt=%0d want 1/4/3", trig, progress, fire_cnt); end
      step(0, '0, 1);
   endtask

   task automatic test_clear_collide;
      step(1, P0, 0); step(1, P1, 0); step(1, P2, 0); step(1, P3, 0);
      step(0, '0, 1);
      step(0, '0, 0);
      n_vec++; if (trig !== 1'b0 || progress !== 3'd0 || fire_cnt !== 8'd3) begin n_err++; $display("FAIL clear_wins got trig=%0b prog=%0d cnt=%0d want 0/0/3", trig, progress, fire_cnt); end
      step(1, P0, 0); step(1, P1, 0); step(1, P2, 0); step(1, P3, 1);
      step(0, '0, 0); step(0, '0, 0);
      n_vec++; if (trig !== 1'b0 || progress !== 3'd0 || fire_cnt !== 8'd3) begin n_err++; $display("FAIL clear_flush got trig=%0b prog=%0d cnt=%0d want 0/0/3", trig, progress, fire_cnt); end
   endtask

   task automatic test_async_reset;
      step(1, P0, 0); step(1, P1, 0); step(1, P2, 0); step(0, '0, 0);
      n_vec++; if (progress !== 3'd3) begin n_err++; $display("FAIL pre_reset_progress got %0d want 3", progress); end
      #1 rst = 1'b0;
      #1;
      n_vec++; if (trig !== 1'b0 || progress !== 3'd0 || fire_cnt !== 8'd0) begin n_err++; $display("FAIL async_reset got trig=%0b prog=%0d cnt=%0d want 0/0/0", trig, progress, fire_cnt); end
      @(posedge clk); #1; rst = 1'b1;
   endtask

   task automatic test_saturate;
      for (int r = 0; r < 300; r++) begin
         step(1, P0, 0); step(1, P1, 0); step(1, P2, 0); step(1, P3, 0); step(0, '0, 0);
         if (r == 253) begin
            n_vec++; if (fire_cnt !== 8'd254) begin n_err++; $display("FAIL sat_254 got %0d want 254", fire_cnt); end
         end
         step(0, '0, 1);
      end
      n_vec++; if (fire_cnt !== 8'hff) begin n_err++; $display("FAIL sat_ff got %0d want 255", fire_cnt); end
   endtask

   task automatic test_seq1;
      step1(1, JUNK, 0); step1(0, '0, 0);
      n_vec++; if (trig1 !== 1'b0) begin n_err++; $display("FAIL seq1_junk got %0b want 0", trig1); end
      step1(1, DEFAULT_PATTERN, 0);
      n_vec++; if (trig1 !== 1'b0) begin n_err++; $display("FAIL seq1_early got %0b want 0", trig1); end
      step1(0, '0, 0);
      n_vec++; if (trig1 !== 1'b1 || progress1 !== 1'b1 || fire_cnt1 !== 8'd1) begin n_err++; $display("FAIL seq1_fire got trig=%0b prog=%0d cnt=%0d want 1/1/1", trig1, progress1, fire_cnt1); end
`ifdef TROJAN_TRIG_MASK_EN
      step1(0, '0, 1);
      mask1 = '0;
      step1(1, JUNK, 0); step1(0, '0, 0);
      n_vec++; if (trig1 !== 1'b1 || fire_cnt1 !== 8'd2) begin n_err++; $display("FAIL mask0_fire got trig=%0b cnt=%0d want 1/2", trig1, fire_cnt1); end
`endif
   endtask

   initial begin
      test_reset();
      test_basic();
      test_gap();
      test_restart();
      test_clear_collide();
      test_async_reset();
      test_saturate();
      test_seq1();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
